// File: rtl/channel_scheduler.sv
// Round-robin scheduler for Up/Down step commands from two requesters onto the
// Ch1/Ch2 control lines, with stretched pulses, a hold-off gap and saturating positions.
module channel_scheduler #(
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 4,
    parameter int POS_W        = 4,
    parameter int POS_MAX      = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req1,
    input  logic             Sel1,
    input  logic             Dir1,
    output logic             Ack1,
    input  logic             Req2,
    input  logic             Sel2,
    input  logic             Dir2,
    output logic             Ack2,
    output logic             Ch1_up,
    output logic             Ch1_down,
    output logic             Ch2_up,
    output logic             Ch2_down,
    output logic [POS_W-1:0] Pos1,
    output logic [POS_W-1:0] Pos2,
    output logic             Err,
    output logic             Busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int CNT_MAX = (PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_ZERO   = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
    localparam logic [POS_W-1:0] POS_TOP    = POS_W'(POS_MAX);

    logic [1:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             prio_r, prio_nxt_s;      // 0: requester 1 wins a tie, 1: requester 2
    logic [POS_W-1:0] pos1_r, pos1_nxt_s;
    logic [POS_W-1:0] pos2_r, pos2_nxt_s;
    logic [3:0]       ch_r, ch_nxt_s;          // {ch2_down, ch2_up, ch1_down, ch1_up}
    logic             ack1_r, ack1_nxt_s;
    logic             ack2_r, ack2_nxt_s;
    logic             err_r, err_nxt_s;
    logic             busy_r, busy_nxt_s;

    logic             grant_s;
    logic             grant_two_s;
    logic             sel_s;
    logic             dir_s;
    logic [POS_W-1:0] cur_pos_s;
    logic             legal_s;

    // Arbitration among the requests sampled in IDLE and legality of the winning step
    always_comb begin
        grant_s     = 1'b0;
        grant_two_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (Req1 && Req2) begin
                grant_s     = 1'b1;
                grant_two_s = prio_r;
            end else if (Req1) begin
                grant_s     = 1'b1;
                grant_two_s = 1'b0;
            end else if (Req2) begin
                grant_s     = 1'b1;
                grant_two_s = 1'b1;
            end else begin
                grant_s     = 1'b0;
                grant_two_s = 1'b0;
            end
        end else begin
            grant_s     = 1'b0;
            grant_two_s = 1'b0;
        end
        sel_s     = grant_two_s ? Sel2 : Sel1;
        dir_s     = grant_two_s ? Dir2 : Dir1;
        cur_pos_s = sel_s ? pos2_r : pos1_r;
        legal_s   = dir_s ? (cur_pos_s < POS_TOP) : (cur_pos_s != POS_ZERO);
    end

    // Next-state and next-output computation for the IDLE/PULSE/HOLD sequence
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        prio_nxt_s  = prio_r;
        pos1_nxt_s  = pos1_r;
        pos2_nxt_s  = pos2_r;
        ch_nxt_s    = ch_r;
        ack1_nxt_s  = 1'b0;
        ack2_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    ack1_nxt_s = ~grant_two_s;
                    ack2_nxt_s = grant_two_s;
                    prio_nxt_s = ~grant_two_s;
                    if (legal_s) begin
                        state_nxt_s = ST_PULSE;
                        cnt_nxt_s   = PULSE_LOAD;
                        ch_nxt_s    = 4'b0001 << {sel_s, ~dir_s};
                        if (sel_s) begin
                            pos2_nxt_s = dir_s ? (pos2_r + POS_ONE) : (pos2_r - POS_ONE);
                        end else begin
                            pos1_nxt_s = dir_s ? (pos1_r + POS_ONE) : (pos1_r - POS_ONE);
                        end
                    end else begin
                        // Out-of-range step: acknowledge, flag, and skip the pulse entirely
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_HOLD;
                        cnt_nxt_s   = HOLD_LOAD;
                        ch_nxt_s    = 4'b0000;
                    end
                end else begin
                    ch_nxt_s = 4'b0000;
                end
            end
            ST_PULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = HOLD_LOAD;
                    ch_nxt_s    = 4'b0000;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
                ch_nxt_s = 4'b0000;
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                ch_nxt_s    = 4'b0000;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            prio_r  <= 1'b0;
            pos1_r  <= POS_ZERO;
            pos2_r  <= POS_ZERO;
            ch_r    <= 4'b0000;
            ack1_r  <= 1'b0;
            ack2_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            prio_r  <= prio_nxt_s;
            pos1_r  <= pos1_nxt_s;
            pos2_r  <= pos2_nxt_s;
            ch_r    <= ch_nxt_s;
            ack1_r  <= ack1_nxt_s;
            ack2_r  <= ack2_nxt_s;
            err_r   <= err_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign Ack1     = ack1_r;
    assign Ack2     = ack2_r;
    assign Ch1_up   = ch_r[0];
    assign Ch1_down = ch_r[1];
    assign Ch2_up   = ch_r[2];
    assign Ch2_down = ch_r[3];
    assign Pos1     = pos1_r;
    assign Pos2     = pos2_r;
    assign Err      = err_r;
    assign Busy     = busy_r;

endmodule

// File: tb/tb_channel_scheduler.sv
// Scoreboard bench for channel_scheduler: directed requests push expected grants,
// a negedge monitor pops and compares on every Ack.
module tb_channel_scheduler;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Req1 = 1'b0, Sel1 = 1'b0, Dir1 = 1'b0;
    logic       Req2 = 1'b0, Sel2 = 1'b0, Dir2 = 1'b0;
    logic       Ack1, Ack2, Ch1_up, Ch1_down, Ch2_up, Ch2_down, Err, Busy;
    logic [3:0] Pos1, Pos2;

    channel_scheduler dut (
        .Clk(Clk), .Reset(Reset),
        .Req1(Req1), .Sel1(Sel1), .Dir1(Dir1), .Ack1(Ack1),
        .Req2(Req2), .Sel2(Sel2), .Dir2(Dir2), .Ack2(Ack2),
        .Ch1_up(Ch1_up), .Ch1_down(Ch1_down), .Ch2_up(Ch2_up), .Ch2_down(Ch2_down),
        .Pos1(Pos1), .Pos2(Pos2), .Err(Err), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         who;
        logic       err;
        logic [3:0] ch;
        logic [3:0] pos1;
        logic [3:0] pos2;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   mpos1 = 0;
    int   mpos2 = 0;
    bit   width_en = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the step a given grant should produce
    function automatic void push_exp(input int who, input logic sel, input logic dir);
        exp_t e;
        int   p;
        p = sel ? mpos2 : mpos1;
        e.who = who;
        e.err = dir ? (p >= 15) : (p == 0);
        if (e.err) e.ch = 4'b0000;
        else if (!sel && dir) e.ch = 4'b0001;
        else if (!sel && !dir) e.ch = 4'b0010;
        else if (sel && dir) e.ch = 4'b0100;
        else e.ch = 4'b1000;
        if (!e.err) begin
            if (sel) mpos2 = dir ? mpos2 + 1 : mpos2 - 1;
            else mpos1 = dir ? mpos1 + 1 : mpos1 - 1;
        end
        e.pos1 = 4'(mpos1);
        e.pos2 = 4'(mpos2);
        exp_q.push_back(e);
    endfunction

    // Monitor: invariants every cycle, scoreboard compare on Ack, optional pulse-width check
    initial begin
        exp_t       e;
        logic [3:0] chv;
        logic [3:0] wch;
        int         wk;
        wk = 0;
        wch = 4'b0000;
        forever begin
            @(negedge Clk);
            chv = {Ch2_down, Ch2_up, Ch1_down, Ch1_up};
            chk("ch_onehot0", int'($countones(chv) <= 1), 1);
            chk("ack_exclusive", int'(Ack1 && Ack2), 0);
            if (wk == 1) begin
                chk("pulse_2nd_cycle", int'(chv), int'(wch));
                wk = 2;
            end else if (wk == 2) begin
                chk("pulse_end", int'(chv), 0);
                wk = 0;
            end
            if (Ack1 || Ack2) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_who", Ack2 ? 2 : 1, e.who);
                    chk("err", int'(Err), int'(e.err));
                    chk("ch_at_ack", int'(chv), int'(e.ch));
                    chk("pos1", int'(Pos1), int'(e.pos1));
                    chk("pos2", int'(Pos2), int'(e.pos2));
                    chk("busy_at_ack", int'(Busy), 1);
                    if (width_en && e.ch != 4'b0000) begin
                        wk = 1;
                        wch = e.ch;
                    end
                end
            end else begin
                chk("err_without_ack", int'(Err), 0);
            end
        end
    end

    // Raise a request, wait (bounded) for its Ack, drop the request; returns the Ack cycle
    task automatic issue(input int who, input logic sel, input logic dir,
                         input bit do_push, output int ack_cyc);
        bit got;
        got = 1'b0;
        ack_cyc = -1;
        if (do_push) push_exp(who, sel, dir);
        if (who == 1) begin Req1 = 1'b1; Sel1 = sel; Dir1 = dir; end
        else begin Req2 = 1'b1; Sel2 = sel; Dir2 = dir; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clk);
            if ((who == 1 && Ack1) || (who == 2 && Ack2)) begin
                got = 1'b1;
                ack_cyc = cyc;
            end
        end
        if (who == 1) Req1 = 1'b0;
        else Req2 = 1'b0;
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge Clk);
            idle = !Busy;
        end
        if (!idle) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        mpos1 = 0;
        mpos2 = 0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, a1_0, a1_1, a2_0, a2_1, r1, r2, rc;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_ch", int'({Ch2_down, Ch2_up, Ch1_down, Ch1_up}), 0);
        chk("rst_ack", int'({Ack1, Ack2}), 0);
        chk("rst_err", int'(Err), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_pos1", int'(Pos1), 0);
        chk("rst_pos2", int'(Pos2), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Single Ch1 up: pulse t+1..t+2, Busy t+1..t+6
        push_exp(1, 1'b0, 1'b1);
        Req1 = 1'b1; Sel1 = 1'b0; Dir1 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                chk("t1_ack1", int'(Ack1), 1);
                Req1 = 1'b0;
            end
            chk("t1_ch1_up", int'(Ch1_up), (k <= 2) ? 1 : 0);
            chk("t1_busy", int'(Busy), (k <= 6) ? 1 : 0);
            chk("t1_pos1", int'(Pos1), 1);
        end

        // Both requesters held: grants alternate 1,2,1,2 seven cycles apart
        do_reset();
        width_en = 1'b1;
        push_exp(1, 1'b1, 1'b1);
        push_exp(2, 1'b1, 1'b1);
        push_exp(1, 1'b1, 1'b1);
        push_exp(2, 1'b1, 1'b1);
        fork
            begin
                issue(1, 1'b1, 1'b1, 1'b0, a1_0);
                issue(1, 1'b1, 1'b1, 1'b0, a1_1);
            end
            begin
                issue(2, 1'b1, 1'b1, 1'b0, a2_0);
                issue(2, 1'b1, 1'b1, 1'b0, a2_1);
            end
        join
        chk("t2_gap_a", a2_0 - a1_0, 7);
        chk("t2_gap_b", a1_1 - a2_0, 7);
        chk("t2_gap_c", a2_1 - a1_1, 7);
        wait_idle();
        width_en = 1'b0;

        // Reset mid-pulse (Ch1_down, Pos1=3); priority must return to requester 1
        do_reset();
        repeat (4) issue(1, 1'b0, 1'b1, 1'b1, c1);
        issue(1, 1'b0, 1'b0, 1'b1, c1);
        chk("t5_ch1_down", int'(Ch1_down), 1);
        chk("t5_pos1_pre", int'(Pos1), 3);
        Reset = 1'b1;
        mpos1 = 0;
        mpos2 = 0;
        Req1 = 1'b1; Sel1 = 1'b1; Dir1 = 1'b1;
        Req2 = 1'b1; Sel2 = 1'b1; Dir2 = 1'b0;
        push_exp(1, 1'b1, 1'b1);
        push_exp(2, 1'b1, 1'b0);
        @(negedge Clk);
        chk("t5_ch_cleared", int'({Ch2_down, Ch2_up, Ch1_down, Ch1_up}), 0);
        chk("t5_pos1", int'(Pos1), 0);
        chk("t5_busy", int'(Busy), 0);
        rc = cyc;
        Reset = 1'b0;
        fork
            issue(1, 1'b1, 1'b1, 1'b0, r1);
            issue(2, 1'b1, 1'b0, 1'b0, r2);
        join
        chk("t5_first_grant", r1 - rc, 1);
        chk("t5_second_grant", r2 - r1, 7);

        // Ch1 down from 0: rejected, next grant five cycles later
        issue(1, 1'b0, 1'b0, 1'b1, c1);
        issue(1, 1'b0, 1'b1, 1'b1, c2);
        chk("t3_err_gap", c2 - c1, 5);
        wait_idle();

        // Ch2 up 16 times from 0: saturates at 15, last one rejected
        width_en = 1'b1;
        for (int i = 0; i < 16; i++) issue(2, 1'b1, 1'b1, 1'b1, c1);
        for (int k = 0; k < 3; k++) begin
            chk("t4_no_ch2_up", int'(Ch2_up), 0);
            chk("t4_pos2_sat", int'(Pos2), 15);
            @(negedge Clk);
        end
        wait_idle();
        width_en = 1'b0;
        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
